// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding, slice width and elaboration-time helpers.
package nibble_add_seq_pkg;

    // Width of the single adder slice reused on every RUN cycle.
    localparam int NIBBLE_W = 4;

    // Sequencer states; the encoding is also exposed on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the nibble index.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

    // Number of nibble steps needed to cover an operand of the given width.
    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_add_seq_add4.sv
// Combinational 4-bit adder slice with carry in and carry out.
module add4_cin
    import nibble_add_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    // Five-bit sum so the slice carry falls out of the top bit.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-precision add/subtract sequencer. One 4-bit adder slice is walked
// across the operands least-significant nibble first, with the carry held
// in a register between nibbles. Host handshake is start/ready in, done out.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1 (IDLE or DONE). The result on sum/cout/ovf is valid from the
// cycle done=1 and is held until the next accepted request. start while
// busy=1 is ignored and nothing is queued.
//
// WIDTH must be a multiple of 4 and at least 8.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [IDX_W+1:0] bit_base;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_c;
    logic             last;

    // Bit offset of the nibble currently being processed (idx * 4).
    assign bit_base = {idx, 2'b00};
    assign nib_a    = a_r[bit_base +: NIBBLE_W];
    assign nib_b    = b_r[bit_base +: NIBBLE_W];
    assign last     = (idx == LAST_IDX);

    add4_cin u_add4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Status flags decode straight from the state register, so they are
    // glitch-free and change only on clock edges.
    assign ready     = (state == ST_IDLE) || (state == ST_DONE);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    // Sequencer: accept operands, step one nibble per RUN cycle, then report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b here and seed
                        // the carry with 1 so the datapath only ever adds.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum[bit_base +: NIBBLE_W] <= nib_s;
                    carry                     <= nib_c;
                    if (last) begin
                        // Overflow: operand signs (after b inversion) agree
                        // but the result sign differs from them.
                        cout  <= nib_c;
                        ovf   <= (a_r[WIDTH-1] ~^ b_r[WIDTH-1]) &
                                 (nib_s[3] ^ a_r[WIDTH-1]);
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq at WIDTH=16. Expected results come
// from an integer-arithmetic model of add/subtract with carry and signed
// overflow; timing expectations come from the documented latency.
module tb_nibble_add_seq;

  localparam int W   = 16;
  localparam int NIB = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  int errors;
  int checks;

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub_i),
    .a         (a_i),
    .b         (b_i),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer add/subtract.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, output logic [W-1:0] r,
                                 output logic co, output logic ov);
    int ua, ub, sa, sb, u, sres;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - 65536 : ua;
    sb = b[W-1] ? ub - 65536 : ub;
    if (!s) begin
      u    = ua + ub;
      co   = (u > 65535);
      sres = sa + sb;
    end else begin
      u    = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end
    r  = u[W-1:0];
    ov = (sres > 32767) || (sres < -32768);
  endfunction

  // Driver: wait on negedges until done or budget runs out.
  task automatic wait_done(input int budget, output int n, output bit got);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    got = done;
  endtask

  // Driver: issue one request at a negedge with ready=1 and collect results.
  // lat counts rising edges from the accepting edge to the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic co, output logic ov,
                        output int lat, output int busy_cnt, output bit got);
    a_i = a; b_i = b; sub_i = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    got = done;
    r = sum; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a_i = 16'hFFFF; b_i = 16'h0001; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h1234};
    logic [W-1:0] tb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h1234};
    logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] r, er;
    logic co, ov, eco, eov;
    int lat, bc;
    bit got;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ref_op(ta[i], tb[i], ts[i], er, eco, eov);
      run_op(ta[i], tb[i], ts[i], r, co, ov, lat, bc, got);
      checks++; if (!got) begin errors++; $display("FAIL dir_done_timeout case=%0d waited=%0d", i, lat); end
      checks++; if (r !== er) begin errors++; $display("FAIL dir_sum case=%0d got=%h exp=%h", i, r, er); end
      checks++; if (co !== eco) begin errors++; $display("FAIL dir_cout case=%0d got=%b exp=%b", i, co, eco); end
      checks++; if (ov !== eov) begin errors++; $display("FAIL dir_ovf case=%0d got=%b exp=%b", i, ov, eov); end
      checks++; if (lat !== NIB + 1) begin errors++; $display("FAIL dir_latency case=%0d got=%0d exp=%0d", i, lat, NIB + 1); end
      checks++; if (bc !== NIB) begin errors++; $display("FAIL dir_busy_cycles case=%0d got=%0d exp=%0d", i, bc, NIB); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, r, er;
    logic rs, co, ov, eco, eov;
    int lat, bc, gap;
    bit got;
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap + 1) @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      ref_op(ra, rb, rs, er, eco, eov);
      run_op(ra, rb, rs, r, co, ov, lat, bc, got);
      checks++; if (!got) begin errors++; $display("FAIL rnd_done_timeout i=%0d", i); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd_sum i=%0d a=%h b=%h sub=%b got=%h exp=%h", i, ra, rb, rs, r, er); end
      checks++; if (co !== eco) begin errors++; $display("FAIL rnd_cout i=%0d a=%h b=%h sub=%b got=%b exp=%b", i, ra, rb, rs, co, eco); end
      checks++; if (ov !== eov) begin errors++; $display("FAIL rnd_ovf i=%0d a=%h b=%h sub=%b got=%b exp=%b", i, ra, rb, rs, ov, eov); end
      checks++; if (lat !== NIB + 1) begin errors++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, lat, NIB + 1); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] er;
    logic eco, eov;
    int n;
    bit got;
    ref_op(16'h1357, 16'h0F0F, 1'b0, er, eco, eov);
    @(negedge clk);
    a_i = 16'h1357; b_i = 16'h0F0F; sub_i = 1'b0; start = 1'b1;
    @(negedge clk);            // RUN cycle 1
    start = 1'b0;
    @(negedge clk);            // RUN cycle 2: new request must be dropped
    a_i = 16'hAAAA; b_i = 16'h5555; sub_i = 1'b1; start = 1'b1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ign_ready_in_run got=%b exp=0", ready); end
    @(negedge clk);
    start = 1'b0;
    wait_done(20, n, got);
    checks++; if (!got) begin errors++; $display("FAIL ign_done_timeout waited=%0d", n); end
    checks++; if (n + 3 !== NIB + 1) begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", n + 3, NIB + 1); end
    checks++; if (sum !== er) begin errors++; $display("FAIL ign_sum got=%h exp=%h", sum, er); end
    checks++; if (cout !== eco) begin errors++; $display("FAIL ign_cout got=%b exp=%b", cout, eco); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart done=%b busy=%b exp=0,0", done, busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] er1, er2;
    logic eco1, eov1, eco2, eov2;
    int n;
    bit got;
    ref_op(16'hFFF0, 16'h0020, 1'b0, er1, eco1, eov1);
    ref_op(16'h0100, 16'h0200, 1'b1, er2, eco2, eov2);
    @(negedge clk);
    a_i = 16'hFFF0; b_i = 16'h0020; sub_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, n, got);
    checks++; if (!got) begin errors++; $display("FAIL b2b_first_timeout waited=%0d", n); end
    checks++; if (sum !== er1 || cout !== eco1) begin errors++; $display("FAIL b2b_first_result got=%h/%b exp=%h/%b", sum, cout, er1, eco1); end
    // Hold start through the DONE cycle with the second operand set.
    a_i = 16'h0100; b_i = 16'h0200; sub_i = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_after_done done=%b busy=%b exp=0,1", done, busy); end
    wait_done(20, n, got);
    checks++; if (!got) begin errors++; $display("FAIL b2b_second_timeout waited=%0d", n); end
    checks++; if (n + 1 !== NIB + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", n + 1, NIB + 1); end
    checks++; if (sum !== er2) begin errors++; $display("FAIL b2b_second_sum got=%h exp=%h", sum, er2); end
    checks++; if (cout !== eco2 || ovf !== eov2) begin errors++; $display("FAIL b2b_second_flags got=%b/%b exp=%b/%b", cout, ovf, eco2, eov2); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] r, er;
    logic co, ov, eco, eov;
    int lat, bc, seen;
    bit got;
    @(negedge clk);
    a_i = 16'h7FFF; b_i = 16'h7FFF; sub_i = 1'b0; start = 1'b1;
    @(negedge clk);            // RUN cycle 1
    start = 1'b0;
    @(negedge clk);            // RUN cycle 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_ready ready=%b busy=%b exp=1,0", ready, busy); end
    checks++; if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_outputs sum=%h cout=%b ovf=%b exp=0000,0,0", sum, cout, ovf); end
    seen = 0;
    for (int i = 0; i < 2 * NIB; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done pulses=%0d exp=0", seen); end
    ref_op(16'h4000, 16'h4000, 1'b0, er, eco, eov);
    run_op(16'h4000, 16'h4000, 1'b0, r, co, ov, lat, bc, got);
    checks++; if (!got) begin errors++; $display("FAIL abort_next_timeout waited=%0d", lat); end
    checks++; if (r !== er || co !== eco || ov !== eov) begin errors++; $display("FAIL abort_next_result got=%h/%b/%b exp=%h/%b/%b", r, co, ov, er, eco, eov); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
